// File: rtl/spi_pkg.sv
// Shared SPI definitions: command codes, master FSM states and frame geometry.
package spi_pkg;

   localparam int unsigned ADDR_SIZE_DEFAULT = 8;
   localparam int unsigned FRAME_W           = ADDR_SIZE_DEFAULT + 2;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_SHIFT,
      ST_WAIT,
      ST_RECV,
      ST_GAP
   } state_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Up-counter with synchronous reset, synchronous clear and count enable.
module spi_bit_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI master: sends one command frame per request and, for read-data frames,
// collects ADDR_SIZE bits from MISO after a fixed turnaround.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned ADDR_SIZE  = ADDR_SIZE_DEFAULT,
   parameter int unsigned TURNAROUND = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic [ADDR_SIZE+1:0] req_data,
   output logic                 req_ready,
   output logic                 SS_n,
   output logic                 MOSI,
   input  logic                 MISO,
   output logic [ADDR_SIZE-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 busy
);

   localparam int unsigned FRAME_LEN = ADDR_SIZE + 2;
   localparam int unsigned CNT_W     = $clog2(max3(FRAME_LEN, TURNAROUND, ADDR_SIZE) + 1);

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
   localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(ADDR_SIZE - 1);

   state_t                 state, state_next;
   cmd_t                   cmd;
   logic [FRAME_LEN-1:0]   shreg;
   logic [ADDR_SIZE-2:0]   rx;
   logic [ADDR_SIZE-1:0]   rx_next;
   logic [CNT_W-1:0]       cnt;
   logic                   cnt_clr, cnt_en;

   // Counter restarts on every state change and only runs in timed states.
   assign cnt_clr = (state_next != state);
   assign cnt_en  = (state == ST_SHIFT) || (state == ST_WAIT) || (state == ST_RECV);
   assign rx_next = {rx, MISO};

   spi_bit_counter #(.WIDTH(CNT_W)) u_bit_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (cnt)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (req_valid) state_next = ST_START;
         ST_START: state_next = ST_SHIFT;
         ST_SHIFT: begin
            if (cnt == SHIFT_LAST) begin
               if (cmd == CMD_RD_DATA) begin
                  state_next = (TURNAROUND > 0) ? ST_WAIT : ST_RECV;
               end else begin
                  state_next = ST_GAP;
               end
            end
         end
         ST_WAIT:  if (cnt == WAIT_LAST) state_next = ST_RECV;
         ST_RECV:  if (cnt == RECV_LAST) state_next = ST_GAP;
         ST_GAP:   state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      SS_n      = 1'b0;
      MOSI      = 1'b0;
      busy      = 1'b1;
      req_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            SS_n      = 1'b1;
            busy      = 1'b0;
            req_ready = 1'b1;
         end
         ST_START, ST_SHIFT: MOSI = shreg[FRAME_LEN-1];
         ST_GAP:             SS_n = 1'b1;
         default: ;
      endcase
   end

   // START shows the MSB without shifting, so SHIFT drives every frame bit once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cmd      <= CMD_WR_ADDR;
         shreg    <= '0;
         rx       <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         state    <= state_next;
         rd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  shreg <= req_data;
                  cmd   <= cmd_t'(req_data[FRAME_LEN-1 -: 2]);
               end
            end
            ST_SHIFT: shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
            ST_RECV: begin
               rx <= rx_next[ADDR_SIZE-2:0];
               if (cnt == RECV_LAST) begin
                  rd_data  <= rx_next;
                  rd_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: per-cycle frame-timeline model, slave MISO model and
// directed scenarios with hand-computed literal expectations.
module tb_spi_master;

   localparam int unsigned AS   = 8;
   localparam int unsigned TA   = 3;
   localparam int unsigned FW   = AS + 2;
   localparam int unsigned RX_0 = 1 + FW + TA;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [FW-1:0] req_data;
   logic          req_ready;
   logic          SS_n;
   logic          MOSI;
   logic          MISO;
   logic [AS-1:0] rd_data;
   logic          rd_valid;
   logic          busy;

   spi_master #(.ADDR_SIZE(AS), .TURNAROUND(TA)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: one entry per non-idle cycle ----------
   typedef struct packed {
      logic          ss_n;
      logic          mosi;
      logic          chk_mosi;
      logic          rv;
      logic [AS-1:0] rd;
   } exp_t;

   exp_t          q[$];
   logic          chk_en     = 1'b0;
   logic          model_idle = 1'b1;
   logic [AS-1:0] model_rd   = '0;
   logic [AS-1:0] slave_byte = '0;

   function automatic exp_t mk(input logic s, input logic m, input logic cm,
                               input logic v, input logic [AS-1:0] r);
      exp_t e;
      e.ss_n = s; e.mosi = m; e.chk_mosi = cm; e.rv = v; e.rd = r;
      return e;
   endfunction

   function automatic void build(input logic [FW-1:0] d, input logic [AS-1:0] b);
      logic is_rd;
      is_rd = (d[FW-1:FW-2] == 2'b11);
      q.push_back(mk(1'b0, d[FW-1], 1'b1, 1'b0, '0));
      for (int i = FW - 1; i >= 0; i--) q.push_back(mk(1'b0, d[i], 1'b1, 1'b0, '0));
      if (is_rd) begin
         for (int i = 0; i < TA; i++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, '0));
         for (int i = 0; i < AS; i++) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
      end
      q.push_back(mk(1'b1, 1'b0, 1'b0, is_rd, b));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         model_rd = '0;
         chk_en   = 1'b1;
      end else if (chk_en && model_idle && req_valid) begin
         build(req_data, slave_byte);
      end
   end

   always @(negedge clk) begin : compare
      exp_t e;
      logic bsy;
      if (chk_en) begin
         if (q.size() > 0) begin
            e = q.pop_front();
            bsy = 1'b1;
         end else begin
            e = mk(1'b1, 1'b0, 1'b1, 1'b0, '0);
            bsy = 1'b0;
         end
         model_idle = !bsy;
         if (e.rv) model_rd = e.rd;
         check("ss_n", 32'(SS_n), 32'(e.ss_n));
         if (e.chk_mosi) check("mosi", 32'(MOSI), 32'(e.mosi));
         check("busy", 32'(busy), 32'(bsy));
         check("req_ready", 32'(req_ready), 32'(!bsy));
         check("rd_valid", 32'(rd_valid), 32'(e.rv));
         check("rd_data", 32'(rd_data), 32'(model_rd));
      end
   end

   // ---------------- slave model: answers during the receive window ----------
   int unsigned low_idx = 0;
   always @(negedge clk) begin
      if (SS_n !== 1'b0) begin
         low_idx = 0;
         MISO    = 1'($urandom_range(0, 1));
      end else begin
         if (low_idx >= RX_0 && low_idx < RX_0 + AS) MISO = slave_byte[AS - 1 - (low_idx - RX_0)];
         else MISO = 1'($urandom_range(0, 1));
         low_idx++;
      end
   end

   // ---------------- bus monitor for literal checks ---------------------------
   int          cyc = 0;
   int          low_len = 0;
   int          rise_cyc = 0;
   int          rv_count = 0;
   int          runs[$];
   int          gaps[$];
   logic        prev_ss = 1'b1;
   logic [31:0] mosi_log = '0;

   always @(negedge clk) begin
      cyc++;
      if (SS_n === 1'b0) begin
         if (prev_ss) begin
            gaps.push_back(cyc - rise_cyc);
            low_len  = 0;
            mosi_log = '0;
         end
         low_len++;
         mosi_log = {mosi_log[30:0], MOSI};
      end else if (prev_ss === 1'b0) begin
         runs.push_back(low_len);
         rise_cyc = cyc;
      end
      if (rd_valid === 1'b1) rv_count++;
      prev_ss = (SS_n === 1'b0) ? 1'b0 : 1'b1;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [FW-1:0] d);
      req_data  = d;
      req_valid = 1'b1;
      cycles(1);
      req_valid = 1'b0;
   endtask

   int n0;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_data = '0;
      cycles(2);
      rst = 1'b0;
      cycles(5);
      check("idle_no_frame", 32'(runs.size()), 32'd0);

      send(10'h0A5);
      cycles(20);
      check("wr_addr_low_len", 32'(runs[$]), 32'd11);
      check("wr_addr_mosi", 32'(mosi_log[10:0]), 32'h0A5);

      slave_byte = 8'hC3;
      rv_count = 0;
      send(10'h300);
      cycles(30);
      check("rd_data_low_len", 32'(runs[$]), 32'd22);
      check("rd_data_value", 32'(rd_data), 32'hC3);
      check("rd_valid_pulses", 32'(rv_count), 32'd1);

      slave_byte = 8'h3C;
      send(10'h2F0);
      cycles(20);
      check("rd_addr_keeps_data", 32'(rd_data), 32'hC3);

      req_data = 10'h010; req_valid = 1'b1;
      cycles(1);
      req_data = 10'h1FF;
      cycles(13);
      req_valid = 1'b0;
      cycles(20);
      check("b2b_len_1", 32'(runs[$-1]), 32'd11);
      check("b2b_len_2", 32'(runs[$]), 32'd11);
      check("b2b_gap", 32'(gaps[$]), 32'd2);
      check("b2b_mosi_2", 32'(mosi_log[10:0]), 32'h1FF);

      n0 = runs.size();
      send(10'h155);
      cycles(3);
      req_data = 10'h0FF; req_valid = 1'b1;
      cycles(1);
      req_valid = 1'b0;
      cycles(20);
      check("busy_drop_frames", 32'(runs.size()), 32'(n0 + 1));

      slave_byte = 8'h5A;
      send(10'h3AA);
      cycles(30);
      check("rd_data_second", 32'(rd_data), 32'h5A);

      slave_byte = 8'h96;
      rv_count = 0;
      req_data = 10'h301; req_valid = 1'b1;
      cycles(1);
      req_valid = 1'b0;
      cycles(18);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cycles(5);
      check("abort_low_len", 32'(runs[$]), 32'd19);
      check("abort_no_pulse", 32'(rv_count), 32'd0);
      check("abort_rd_data", 32'(rd_data), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
